// File: rtl/act_pkg.sv
// act_pkg: shared types, widths and FSM states for the activation dispatcher
package act_pkg;
    localparam int ACC_W = 16;
    localparam int OUT_W = 8;

    typedef enum logic [1:0] {
        RELU    = 2'd0,
        TANH    = 2'd1,
        SIGMOID = 2'd2,
        NONE    = 2'd3
    } act_type_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PACK,
        EMIT
    } disp_state_e;

    typedef struct packed {
        act_type_e               act_type;
        logic signed [ACC_W-1:0] data;
    } act_entry_t;
endpackage

// File: rtl/act_disp_fifo.sv
// act_disp_fifo: power-of-two input FIFO of {act_type, data} entries with full/empty flags
module act_disp_fifo
    import act_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  act_entry_t i_wdata,
    output act_entry_t o_rdata,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    act_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    // a pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // storage is written only on accepted pushes and needs no reset
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;

    // pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
endmodule

// File: rtl/act_dispatcher.sv
// act_dispatcher: feeds FIFO entries to an activation unit and packs INT8 results into 32-bit words
// Optional macro ACT_DISP_TIMEOUT_EN adds a WAIT-state timeout with a sticky err_timeout flag.
module act_dispatcher
    import act_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [ACC_W-1:0] s_data,
    input  logic [1:0]              s_act_type,
    output logic                    act_enable,
    output logic [1:0]              act_type,
    output logic signed [ACC_W-1:0] act_data_in,
    input  logic                    act_valid,
    input  logic signed [OUT_W-1:0] act_data_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [4*OUT_W-1:0]      m_data,
    output logic [3:0]              m_keep,
    input  logic                    flush,
    output logic                    busy,
    output logic                    err_timeout
);
    disp_state_e             r_state;
    logic [1:0]              r_byte_cnt;
    logic [OUT_W-1:0]        r_byte;
    logic [4*OUT_W-1:0]      r_lanes;
    logic [3:0]              r_keep;
    logic                    r_m_valid;
    logic                    r_flush_pend;
    logic                    r_act_enable;
    logic [1:0]              r_act_type;
    logic signed [ACC_W-1:0] r_act_data;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_timeout;
    act_entry_t              w_wdata;
    act_entry_t              w_rdata;

    // s_ready is forced low while reset is held so nothing is accepted into a clearing FIFO
    assign s_ready     = !w_full && !rst;
    assign w_push      = s_valid && s_ready;
    assign w_pop       = r_state == IDLE && !w_empty && !r_m_valid;
    assign w_wdata     = '{act_type: act_type_e'(s_act_type), data: s_data};
    assign busy        = r_state != IDLE || !w_empty || r_byte_cnt != 2'd0;
    assign act_enable  = r_act_enable;
    assign act_type    = r_act_type;
    assign act_data_in = r_act_data;
    assign m_valid     = r_m_valid;
    assign m_data      = r_lanes;
    assign m_keep      = r_keep;

    act_disp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata),
        .o_full (w_full),
        .o_empty(w_empty)
    );

`ifdef ACT_DISP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_err;

    assign w_timeout   = r_state == WAIT && !act_valid && r_wait_cnt == TW'(TIMEOUT - 1);
    assign err_timeout = r_err;

    // count WAIT cycles; the error flag stays set until reset
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wait_cnt <= r_state == WAIT ? r_wait_cnt + 1'b1 : '0;
            if (w_timeout) r_err <= 1'b1;
        end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign err_timeout      = 1'b0;
    assign w_unused_timeout = TIMEOUT != 0;
`endif

    // dispatch FSM: issue one entry, wait for its result, pack it, emit full or flushed words
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= IDLE;
            r_byte_cnt   <= 2'd0;
            r_byte       <= '0;
            r_lanes      <= '0;
            r_keep       <= 4'h0;
            r_m_valid    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_act_enable <= 1'b0;
            r_act_type   <= 2'd0;
            r_act_data   <= '0;
        end else begin
            case (r_state)
                IDLE:
                    if (w_pop) begin
                        r_act_enable <= 1'b1;
                        r_act_type   <= w_rdata.act_type;
                        r_act_data   <= w_rdata.data;
                        r_state      <= ISSUE;
                    end else if (w_empty && r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                        if (r_byte_cnt != 2'd0) begin
                            r_m_valid <= 1'b1;
                            r_keep    <= (4'd1 << r_byte_cnt) - 4'd1;
                            r_state   <= EMIT;
                        end
                    end
                ISSUE: begin
                    r_act_enable <= 1'b0;
                    r_state      <= WAIT;
                end
                WAIT:
                    if (act_valid || w_timeout) begin
                        r_byte  <= act_valid ? act_data_out : '0;
                        r_state <= PACK;
                    end
                PACK: begin
                    r_lanes[r_byte_cnt*OUT_W +: OUT_W] <= r_byte;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        r_m_valid <= 1'b1;
                        r_keep    <= 4'hF;
                        r_state   <= EMIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EMIT:
                    if (m_ready) begin
                        r_m_valid  <= 1'b0;
                        r_keep     <= 4'h0;
                        r_lanes    <= '0;
                        r_byte_cnt <= 2'd0;
                        r_state    <= IDLE;
                    end
                default: r_state <= IDLE;
            endcase
            if (flush) r_flush_pend <= 1'b1;
        end
endmodule
